// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - soft-request and sequenced-reset outputs of rst_sequencer
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  soft_rst_req;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  rst_done;
    logic                  soft_rst_ack;
    logic                  busy;

    modport master (
        input  soft_rst_req,
        output stage_rst_n,
        output rst_done,
        output soft_rst_ack,
        output busy
    );

    modport slave (
        output soft_rst_req,
        input  stage_rst_n,
        input  rst_done,
        input  soft_rst_ack,
        input  busy
    );
endinterface

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - synchronized, staged release of domain resets with soft-request restart
module rst_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 8,
    parameter int STAGE_DLY   = 16
) (
    input  logic               clk,
    input  logic               rst,
    rst_sequencer_if.master    bus
);
    localparam int MAX_CNT = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(NUM_STAGES + 1);

    if (NUM_STAGES < 1 || SYNC_STAGES < 2 || HOLD_CYC < 1 || STAGE_DLY < 1) begin : g_param_err
        $error("rst_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_SYNC, S_HOLD, S_REL, S_DONE} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   req_q;
    logic                   soft_edge_q;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [NUM_STAGES-1:0]  stage_q;
    logic                   done_q;
    logic                   ack_q;
    logic                   busy_q;
    logic                   pend_q;

    // Chain fills with ones on rst and drains zeros once rst is released.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            req_q       <= 1'b0;
            soft_edge_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            req_q       <= bus.soft_rst_req;
            soft_edge_q <= bus.soft_rst_req & ~req_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (soft_edge_q && state_q != S_SYNC) begin
                state_q <= S_HOLD;
                cnt_q   <= '0;
                idx_q   <= '0;
                stage_q <= '0;
                done_q  <= 1'b0;
                busy_q  <= 1'b1;
                pend_q  <= 1'b1;
            end else begin
                if (soft_edge_q) begin
                    pend_q <= 1'b1;
                end
                case (state_q)
                    S_SYNC: begin
                        if (!sync_q[SYNC_STAGES-1]) begin
                            state_q <= S_HOLD;
                            cnt_q   <= '0;
                        end
                    end
                    S_HOLD: begin
                        if (cnt_q == CW'(HOLD_CYC - 1)) begin
                            state_q <= S_REL;
                            cnt_q   <= '0;
                            stage_q <= NUM_STAGES'(1);
                            idx_q   <= IW'(1);
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    S_REL: begin
                        if (cnt_q == CW'(STAGE_DLY - 1)) begin
                            cnt_q <= '0;
                            if (idx_q == IW'(NUM_STAGES)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                ack_q   <= pend_q;
                                pend_q  <= 1'b0;
                            end else begin
                                stage_q <= stage_q | (NUM_STAGES'(1) << idx_q);
                                idx_q   <= idx_q + IW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    S_DONE: begin
                        state_q <= S_DONE;
                    end
                    default: begin
                        state_q <= S_SYNC;
                    end
                endcase
            end
        end
    end

    assign bus.stage_rst_n  = stage_q;
    assign bus.rst_done     = done_q;
    assign bus.soft_rst_ack = ack_q;
    assign bus.busy         = busy_q;
endmodule
